shift_add_mult: RTL



---
 rtl/shift_add_mult.sv | 107 ++++++++++
 1 files changed

// File: rtl/shift_add_mult.sv
// shift_add_mult: sequential unsigned shift-and-add multiplier driving a ripple-carry adder once per clock.
module rca #(
    parameter int SIZE = 8
) (
    input  logic [SIZE-1:0] x,
    input  logic [SIZE-1:0] y,
    input  logic            cin,
    output logic [SIZE-1:0] s,
    output logic            cout,
    output logic            ovf
);
    logic [SIZE:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < SIZE; i++) begin : g_fa
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
    assign cout = c[SIZE];
    assign ovf  = c[SIZE] ^ c[SIZE-1];
endmodule

module shift_add_mult #(
    parameter int SIZE = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [SIZE-1:0]   a,
    input  logic [SIZE-1:0]   b,
    output logic              busy,
    output logic              done,
    output logic [2*SIZE-1:0] product
);
    localparam int CW = $clog2(SIZE + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [SIZE-1:0]   m_q, m_d, a_q, a_d, q_q, q_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*SIZE-1:0] product_q, product_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic [SIZE-1:0]   add_s;
    logic              add_c, ovf_unused;
    logic [SIZE:0]     sum;
    rca #(.SIZE(SIZE)) u_rca (
        .x    (a_q),
        .y    (m_q),
        .cin  (1'b0),
        .s    (add_s),
        .cout (add_c),
        .ovf  (ovf_unused)
    );
    // the carry is kept as bit SIZE so it shifts into the top of A
    assign sum = q_q[0] ? {add_c, add_s} : {1'b0, a_q};
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        a_d       = a_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE: if (start) begin
                m_d     = a;
                q_d     = b;
                a_d     = '0;
                cnt_d   = CW'(SIZE);
                state_d = RUN;
            end
            RUN: begin
                a_d   = sum[SIZE:1];
                q_d   = {sum[0], q_q[SIZE-1:1]};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    product_d = {sum[SIZE:1], sum[0], q_q[SIZE-1:1]};
                    state_d   = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d == RUN;
        done_d = state_d == DONE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            m_q       <= '0;
            a_q       <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            a_q       <= a_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end
    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;
endmodule
